// File: rtl/matrix_feeder.sv
// matrix_feeder: holds two 3x3 operand matrices and streams them, skewed in
// time, into a 3x3 systolic array. Each feed run lasts 8 output cycles. The
// block then waits for the array's Done flag, giving up after a bounded number
// of cycles.
module matrix_feeder #(
  parameter int DATAWIDTN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [3:0]           wr_addr,
  input  logic [DATAWIDTN-1:0] wr_data,
  input  logic                 go,
  input  logic                 Done,
  output logic [1:0]           start,
  output logic [DATAWIDTN-1:0] A0,
  output logic [DATAWIDTN-1:0] A1,
  output logic [DATAWIDTN-1:0] A2,
  output logic [DATAWIDTN-1:0] B0,
  output logic [DATAWIDTN-1:0] B1,
  output logic [DATAWIDTN-1:0] B2,
  output logic                 busy,
  output logic                 run_done,
  output logic                 err
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FEED = 2'd1, S_WAIT = 2'd2} state_t;
  typedef logic [DATAWIDTN-1:0] elem_t;

  localparam logic [1:0] START_RUN = 2'b01;
  localparam logic [2:0] LAST_STEP = 3'd7;   // steps 0..7 in FEED
  localparam logic [3:0] LAST_WAIT = 4'd15;  // 16 WAIT cycles before timeout

  elem_t a_mem [0:2][0:2];
  elem_t b_mem [0:2][0:2];

  state_t     state, state_nxt;
  logic [2:0] step, step_nxt;
  logic [3:0] tmo, tmo_nxt;
  logic [1:0] start_nxt;
  logic       run_done_nxt, err_nxt;
  logic       feed_load;
  logic [2:0] feed_step;
  elem_t      a_out [0:2];
  elem_t      b_out [0:2];
  elem_t      a_nxt [0:2];
  elem_t      b_nxt [0:2];
  logic [1:0] wr_row, wr_col;
  logic       wr_ok;
  logic [1:0] lane;
  logic [2:0] diag;

  // Decode the flat write index row*3+col; indices above 8 are rejected.
  always_comb begin
    // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    wr_ok  = 1'b1;
    wr_row = 2'd0;
    wr_col = 2'd0;
    case (wr_addr)
      4'd0: begin wr_row = 2'd0; wr_col = 2'd0; end
      4'd1: begin wr_row = 2'd0; wr_col = 2'd1; end
      4'd2: begin wr_row = 2'd0; wr_col = 2'd2; end
      4'd3: begin wr_row = 2'd1; wr_col = 2'd0; end
      4'd4: begin wr_row = 2'd1; wr_col = 2'd1; end
      4'd5: begin wr_row = 2'd1; wr_col = 2'd2; end
      4'd6: begin wr_row = 2'd2; wr_col = 2'd0; end
      4'd7: begin wr_row = 2'd2; wr_col = 2'd1; end
      4'd8: begin wr_row = 2'd2; wr_col = 2'd2; end
      default: wr_ok = 1'b0;
    endcase
  end

  // Operand stores: writable only while idle and not being asked to start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the stores are small and must read back as zero after reset, so they are flops with reset rather than a RAM macro.
      a_mem <= '{default: '0};
      b_mem <= '{default: '0};
    end else if (wr_en && wr_ok && (state == S_IDLE) && !go) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (wr_sel) b_mem[wr_row][wr_col] <= wr_data;
      else        a_mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Next-state, counters and next output values for the feed sequencer.
  always_comb begin
    state_nxt    = state;
    step_nxt     = step;
    tmo_nxt      = tmo;
    start_nxt    = start;
    run_done_nxt = 1'b0;
    err_nxt      = err;
    feed_load    = 1'b0;
    feed_step    = 3'd0;
    case (state)
      S_IDLE: begin
        if (go) begin
          state_nxt = S_FEED;
          step_nxt  = 3'd0;
          tmo_nxt   = 4'd0;
          start_nxt = START_RUN;
          err_nxt   = 1'b0;
          feed_load = 1'b1;
          feed_step = 3'd0;
        end
      end
      S_FEED: begin
        if (step == LAST_STEP) begin
          state_nxt = S_WAIT;
          tmo_nxt   = 4'd0;
        end else begin
          step_nxt  = step + 3'd1;
          feed_load = 1'b1;
          feed_step = step + 3'd1;
        end
      end
      S_WAIT: begin
        // Done on the final WAIT cycle still counts as success.
        if (Done) begin
          state_nxt    = S_IDLE;
          start_nxt    = 2'b00;
          run_done_nxt = 1'b1;
        end else if (tmo == LAST_WAIT) begin
          state_nxt = S_IDLE;
          start_nxt = 2'b00;
          err_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo + 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Lane k carries A[k][t-k] and B[t-k][k] while 0 <= t-k <= 2, else zero.
    a_nxt = '{default: '0};
    b_nxt = '{default: '0};
    lane  = 2'd0;
    diag  = 3'd0;
    for (int i = 0; i < 3; i++) begin
      lane = 2'(i);
      diag = feed_step - {1'b0, lane};
      if (feed_load && (feed_step >= {1'b0, lane}) && (diag <= 3'd2)) begin
        a_nxt[lane] = a_mem[lane][diag[1:0]];
        b_nxt[lane] = b_mem[diag[1:0]][lane];
      end
    end
  end

  // FSM state and internal counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      step  <= 3'd0;
      tmo   <= 4'd0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      tmo   <= tmo_nxt;
    end
  end

  // Registered outputs toward the array and the host.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start    <= 2'b00;
      a_out    <= '{default: '0};
      b_out    <= '{default: '0};
      busy     <= 1'b0;
      run_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      start    <= start_nxt;
      a_out    <= a_nxt;
      b_out    <= b_nxt;
      busy     <= (state_nxt != S_IDLE);
      run_done <= run_done_nxt;
      err      <= err_nxt;
    end
  end

  assign A0 = a_out[0];
  assign A1 = a_out[1];
  assign A2 = a_out[2];
  assign B0 = b_out[0];
  assign B1 = b_out[1];
  assign B2 = b_out[2];

endmodule

// File: tb/tb_matrix_feeder.sv
// tb_matrix_feeder: directed bench for matrix_feeder. Inputs change 1 ns after
// a rising edge and outputs are checked at that same point, away from the edge.
module tb_matrix_feeder;

  localparam int W = 8;

  // Expected lane streams, one byte per step, t=0 in the top byte.
  localparam logic [63:0] ID_A0 = 64'h01_00_00_00_00_00_00_00;
  localparam logic [63:0] ID_A1 = 64'h00_00_01_00_00_00_00_00;
  localparam logic [63:0] ID_A2 = 64'h00_00_00_00_01_00_00_00;
  localparam logic [63:0] SQ_B0 = 64'h01_04_07_00_00_00_00_00;
  localparam logic [63:0] SQ_B1 = 64'h00_02_05_08_00_00_00_00;
  localparam logic [63:0] SQ_B2 = 64'h00_00_03_06_09_00_00_00;
  localparam logic [63:0] P2_A0 = 64'h10_11_12_00_00_00_00_00;
  localparam logic [63:0] P2_A1 = 64'h00_13_14_15_00_00_00_00;
  localparam logic [63:0] P2_A2 = 64'h00_00_16_17_18_00_00_00;
  localparam logic [63:0] P2_B0 = 64'h20_23_26_00_00_00_00_00;
  localparam logic [63:0] P2_B1 = 64'h00_21_24_27_00_00_00_00;
  localparam logic [63:0] P2_B2 = 64'h00_00_22_25_28_00_00_00;
  localparam logic [63:0] ZERO  = 64'h0;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic         wr_sel;
  logic [3:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         go;
  logic         Done;
  logic [1:0]   start;
  logic [W-1:0] A0, A1, A2, B0, B1, B2;
  logic         busy;
  logic         run_done;
  logic         err;

  int vectors     = 0;
  int miscompares = 0;

  matrix_feeder #(.DATAWIDTN(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .go       (go),
    .Done     (Done),
    .start    (start),
    .A0       (A0),
    .A1       (A1),
    .A2       (A2),
    .B0       (B0),
    .B1       (B1),
    .B2       (B2),
    .busy     (busy),
    .run_done (run_done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane_at(input logic [63:0] v, input int t);
    return v[63 - 8*t -: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic sel, input logic [3:0] addr, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_idle(input string tag, input logic exp_run_done, input logic exp_err);
    check({tag, ".start"}, start, 2'b00);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".run_done"}, run_done, exp_run_done);
    check({tag, ".err"}, err, exp_err);
    check({tag, ".data"}, {A0, A1, A2, B0, B1, B2}, 48'h0);
  endtask

  // Called with step t=0 visible; checks each step, optionally injects a
  // blocked write or a stray Done, and ends with WAIT cycle 0 visible (or
  // returns early with step stop_step visible).
  task automatic check_run(input string tag,
                           input logic [63:0] ea0, input logic [63:0] ea1, input logic [63:0] ea2,
                           input logic [63:0] eb0, input logic [63:0] eb1, input logic [63:0] eb2,
                           input int wr_step, input int done_step, input int stop_step);
    for (int t = 0; t < 8; t++) begin
      if (t == stop_step) return;
      check($sformatf("%s.t%0d.A0", tag, t), A0, lane_at(ea0, t));
      check($sformatf("%s.t%0d.A1", tag, t), A1, lane_at(ea1, t));
      check($sformatf("%s.t%0d.A2", tag, t), A2, lane_at(ea2, t));
      check($sformatf("%s.t%0d.B0", tag, t), B0, lane_at(eb0, t));
      check($sformatf("%s.t%0d.B1", tag, t), B1, lane_at(eb1, t));
      check($sformatf("%s.t%0d.B2", tag, t), B2, lane_at(eb2, t));
      check($sformatf("%s.t%0d.start", tag, t), start, 2'b01);
      check($sformatf("%s.t%0d.busy", tag, t), busy, 1'b1);
      if (t == wr_step) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 4'd0;
        wr_data = 8'h55;
      end
      if (t == done_step) Done = 1'b1;
      tick();
      wr_en = 1'b0;
      Done  = 1'b0;
    end
    check({tag, ".wait0.data"}, {A0, A1, A2, B0, B1, B2}, 48'h0);
    check({tag, ".wait0.start"}, start, 2'b01);
    check({tag, ".wait0.busy"}, busy, 1'b1);
    check({tag, ".wait0.run_done"}, run_done, 1'b0);
  endtask

  // From WAIT cycle 0, wait k more cycles, then pulse Done and check success.
  task automatic finish_with_done(input string tag, input int k);
    repeat (k) tick();
    check({tag, ".waitk.busy"}, busy, 1'b1);
    Done = 1'b1;
    tick();
    Done = 1'b0;
    check({tag, ".done.start"}, start, 2'b00);
    check({tag, ".done.run_done"}, run_done, 1'b1);
    check({tag, ".done.busy"}, busy, 1'b0);
    check({tag, ".done.err"}, err, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = '0;
    go = 1'b0; Done = 1'b0;

    // Reset state.
    #12;
    check_idle("reset", 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // A = identity, B = 1..9 row-major, plus two out-of-range writes.
    for (int i = 0; i < 9; i++) begin
      write(1'b0, 4'(i), (i == 0 || i == 4 || i == 8) ? 8'h01 : 8'h00);
      write(1'b1, 4'(i), 8'(i + 1));
    end
    write(1'b0, 4'd9, 8'hAA);
    write(1'b1, 4'd15, 8'hBB);
    check_idle("loaded", 1'b0, 1'b0);

    // Run 1: Done three cycles into WAIT.
    go = 1'b1;
    tick();
    go = 1'b0;
    check_run("run1", ID_A0, ID_A1, ID_A2, SQ_B0, SQ_B1, SQ_B2, -1, -1, 8);
    finish_with_done("run1", 3);
    tick();
    check_idle("run1.after", 1'b0, 1'b0);

    // Run 2: replay with a blocked write during FEED, then timeout.
    go = 1'b1;
    tick();
    go = 1'b0;
    check_run("run2", ID_A0, ID_A1, ID_A2, SQ_B0, SQ_B1, SQ_B2, 2, -1, 8);
    repeat (15) begin
      tick();
      check("run2.wait.run_done", run_done, 1'b0);
    end
    check("run2.wait15.busy", busy, 1'b1);
    check("run2.wait15.err", err, 1'b0);
    tick();
    check_idle("run2.timeout", 1'b0, 1'b1);
    tick();
    check("run2.err_sticky", err, 1'b1);

    // Run 3: write on the go edge is dropped, err clears, Done on last WAIT cycle wins.
    go = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h77;
    tick();
    go = 1'b0; wr_en = 1'b0;
    check("run3.err_cleared", err, 1'b0);
    check_run("run3", ID_A0, ID_A1, ID_A2, SQ_B0, SQ_B1, SQ_B2, -1, -1, 8);
    finish_with_done("run3", 15);
    tick();

    // New operands for the back-to-back runs.
    for (int i = 0; i < 9; i++) begin
      write(1'b0, 4'(i), 8'(8'h10 + i));
      write(1'b1, 4'(i), 8'(8'h20 + i));
    end

    // Runs 4 and 5: go held high, Done pulsed during FEED, one IDLE cycle between runs.
    go = 1'b1;
    tick();
    check_run("run4", P2_A0, P2_A1, P2_A2, P2_B0, P2_B1, P2_B2, -1, 3, 8);
    finish_with_done("run4", 1);
    tick();
    check("run5.restart.busy", busy, 1'b1);
    check("run5.restart.run_done", run_done, 1'b0);
    check_run("run5", P2_A0, P2_A1, P2_A2, P2_B0, P2_B1, P2_B2, -1, 5, 8);
    go = 1'b0;
    finish_with_done("run5", 0);
    tick();
    check_idle("run5.after", 1'b0, 1'b0);

    // Run 6: reset at step 3 clears outputs at once and wipes the stores.
    go = 1'b1;
    tick();
    go = 1'b0;
    check_run("run6", P2_A0, P2_A1, P2_A2, P2_B0, P2_B1, P2_B2, -1, -1, 3);
    check("run6.t3.A2", A2, 8'h17);
    rst = 1'b1;
    #1;
    check_idle("run6.rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check_idle("run6.after_rst", 1'b0, 1'b0);

    // Run 7: fresh go after reset streams all zeros.
    go = 1'b1;
    tick();
    go = 1'b0;
    check_run("run7", ZERO, ZERO, ZERO, ZERO, ZERO, ZERO, -1, -1, 8);
    finish_with_done("run7", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_feeder.md
MATRIX_FEEDER -- requirements
Module: matrix_feeder

Interface
REQ-001 SHALL have parameter DATAWIDTN, default 8: element width of A/B operands.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 wr_en  input  1  operand write strobe.
REQ-005 wr_sel  input  1  0 = matrix A, 1 = matrix B.
REQ-006 wr_addr  input  4  element index row*3+col, valid 0..8.
REQ-007 wr_data  input  DATAWIDTN  element value.
REQ-008 go  input  1  request one feed run.
REQ-009 Done  input  1  completion flag from the systolic array.
REQ-010 start  output  2  run enable to the array.
REQ-011 A0, A1, A2  output  DATAWIDTN each  skewed A rows 0..2.
REQ-012 B0, B1, B2  output  DATAWIDTN each  skewed B columns 0..2.
REQ-013 busy  output  1  high in FEED or WAIT.
REQ-014 run_done  output  1  one-cycle pulse on a successful run.
REQ-015 err  output  1  sticky timeout flag.

Function
REQ-016 SHALL hold two 3x3 operand stores, A[r][c] and B[r][c], written on an edge with wr_en high, state IDLE and go low.
- Writes with wr_addr > 8, while busy, or with go high SHALL be ignored.
REQ-017 SHALL implement FSM IDLE, FEED, WAIT, with all outputs registered.
REQ-018 IDLE: start=0, A*/B*=0, busy=0.
- go sampled high -> FEED at that edge.
- On that same edge: start<=2'b01, step counter t<=0, and outputs load the t=0 values.
- Clear err on this edge.
REQ-019 FEED, at step t (0..7):
- Ai SHALL output A[i][t-i] when 0 <= t-i <= 2, else 0.
- Bj SHALL output B[t-j][j] when 0 <= t-j <= 2, else 0.
- Steps 5..7 therefore output all zeros.
REQ-020 FEED SHALL last exactly 8 output cycles (t=0..7) with start=2'b01 throughout.
- The edge ending t=7 enters WAIT.
- Data outputs become 0; start stays 2'b01.
REQ-021 go and Done sampled during FEED SHALL be ignored.
REQ-022 WAIT: a timeout counter starts at 0 and increments each cycle.
- Done sampled high -> start<=0, run_done<=1 for exactly one cycle, then IDLE.
REQ-023 WAIT timeout: if Done is not seen within 16 WAIT cycles:
- start<=0, err<=1, no run_done, then IDLE.
- err SHALL stay high until the next accepted go.
REQ-024 Done and timeout on the same edge: Done SHALL win (success, err unchanged).
REQ-025 go held high continuously SHALL start a new run from the first IDLE cycle after completion, never earlier.
REQ-026 Operand stores SHALL be unchanged by a run, so repeated go replays identical streams.
REQ-027 Output values are plain copies of stored elements: no arithmetic, no width change.

Reset
REQ-028 rst high SHALL asynchronously force:
- state IDLE, t=0, timeout counter=0
- start=0, A0..A2=0, B0..B2=0
- busy=0, run_done=0, err=0
- all operand store elements = 0
REQ-029 rst asserted mid-FEED or mid-WAIT SHALL abort the run with no run_done pulse.
- After release the block SHALL accept a fresh go normally.

Verification
REQ-030 Load A=identity and B=[1..9] row-major, then pulse go:
- A0 over t=0..4: 1,0,0,0,0
- A1: 0,0,1,0,0
- A2: 0,0,0,0,1
- B0: 1,4,7,0,0
- B1: 0,2,5,8,0
- B2: 0,0,3,6,9
- t=5..7 all zero; start=01 for 8 cycles.
REQ-031 Done asserted 3 cycles into WAIT:
- start drops on the next edge, run_done high exactly 1 cycle, busy low.
- A second go replays identical streams.
REQ-032 Done never asserted:
- err=1 after 16 WAIT cycles, start=0, no run_done.
- err clears on the next accepted go.
REQ-033 Illegal and blocked writes:
- wr_addr=9 in IDLE -> no store change.
- wr_en during FEED (A[0][0]<=0x55) -> stream and store unchanged.
- go and wr_en on the same IDLE edge -> write dropped, run starts.
REQ-034 rst pulse at FEED t=3:
- All outputs 0 immediately.
- Stores read back as zero on the next run (A*/B* all 0 for t=0..7).
REQ-035 go held high with Done pulsed during FEED:
- Done ignored, FEED still 8 cycles.
- Back-to-back runs separated by exactly one IDLE cycle.
